// File: rtl/hazard_unit_p_if.sv
// Purpose: groups the ID-stage decode fields and the hazard controls exchanged with the hazard unit.
// Latency: none, this is a plain bundle of wires.
// Backpressure: pc_hold / idex_bub / ex_hold flow back from the slave to the pipeline registers.
interface hazard_unit_p_if #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 2
);
  // decode fields of the instruction sitting in ID, plus the EX branch outcome
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regw;
  logic              id_load;
  logic              id_mul;
  logic              br_taken;

  // controls back to the pipeline registers and EX operand muxes
  logic                   pc_hold;
  logic                   idex_bub;
  logic                   ex_hold;
  logic [FLUSH_DEPTH-1:0] flush;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic                   mul_busy;

  // the hazard unit itself
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_regw, id_load, id_mul, br_taken,
    output pc_hold, idex_bub, ex_hold, flush, fwd_a, fwd_b, mul_busy
  );

  // the pipeline (decode stage and branch resolution)
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_regw, id_load, id_mul, br_taken,
    input  pc_hold, idex_bub, ex_hold, flush, fwd_a, fwd_b, mul_busy
  );
endinterface

// File: rtl/hazard_unit_p.sv
// Purpose: shadow scoreboard of EX/MEM/WB driving forwarding selects, load-use stall, MUL hold and branch flush.
// Latency: all outputs are combinational from registered scoreboard state and the current ID fields.
// Backpressure: a load-use hazard stalls IF/ID for one cycle; a MUL stalls IF/ID and ID/EX for MUL_LAT-1 cycles.
module hazard_unit_p #(
  parameter int REG_AW      = 5,
  parameter int MUL_LAT     = 4,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  hazard_unit_p_if.slave hz
);

  localparam int            CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Downstream entries only need what a forwarding source is matched on.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              regw;
  } pipe_ent_t;

  // The EX entry also carries its sources (forwarding) and the load flag
  // (load-use). MUL occupancy is tracked by the counter, not by a flag.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              regw;
    logic              load;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } ex_ent_t;

  ex_ent_t   ex_q,  ex_d;
  pipe_ent_t mem_q, mem_d;
  pipe_ent_t wb_q,  wb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic mul_busy;
  logic br_eff;
  logic luse;
  logic ex_is_load_src;
  logic take_id;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  // Selects the youngest older producer of src; EX/MEM wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic              ex_vld,
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input pipe_ent_t         mem_e,
    input pipe_ent_t         wb_e
  );
    logic mem_hit;
    logic wb_hit;
    mem_hit = mem_e.vld & mem_e.regw & (mem_e.rd != '0) & (mem_e.rd == src);
    wb_hit  = wb_e.vld  & wb_e.regw  & (wb_e.rd  != '0) & (wb_e.rd  == src);
    if (!(ex_vld & use_src)) begin
      return 2'b00;
    end else if (mem_hit) begin
      return 2'b10;
    end else if (wb_hit) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Hazard detection: MUL occupancy, effective branch and load-use.
  always_comb begin
    mul_busy       = (cnt_q != '0);
    // A branch cannot be resolving in EX while a MUL owns it.
    br_eff         = hz.br_taken & ~mul_busy;
    ex_is_load_src = ex_q.vld & ex_q.load & ex_q.regw & (ex_q.rd != '0);
    luse           = hz.id_valid & ex_is_load_src &
                     ((hz.id_use_rs & (hz.id_rs == ex_q.rd)) |
                      (hz.id_use_rt & (hz.id_rt == ex_q.rd)));
    // A taken branch kills the ID instruction, so its load-use stall is moot.
    take_id        = hz.id_valid & ~luse & ~br_eff;
  end

  // Forwarding selects for the instruction currently in EX.
  always_comb begin
    fwd_a_sel = fwd_sel(ex_q.vld, ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b_sel = fwd_sel(ex_q.vld, ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  end

  // Scoreboard advance: hold EX and bubble MEM while the MUL is busy,
  // otherwise shift and admit the ID instruction when allowed.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = mem_q;
    cnt_d = cnt_q;
    if (mul_busy) begin
      mem_d = '0;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      mem_d.vld  = ex_q.vld;
      mem_d.rd   = ex_q.rd;
      mem_d.regw = ex_q.regw;
      if (take_id) begin
        ex_d.vld    = 1'b1;
        ex_d.rd     = hz.id_rd;
        ex_d.regw   = hz.id_regw;
        ex_d.load   = hz.id_load;
        ex_d.rs     = hz.id_rs;
        ex_d.rt     = hz.id_rt;
        ex_d.use_rs = hz.id_use_rs;
        ex_d.use_rt = hz.id_use_rt;
        cnt_d       = hz.id_mul ? MUL_LOAD : '0;
      end else begin
        ex_d  = '0;
        cnt_d = '0;
      end
    end
  end

  // Scoreboard and MUL counter registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are qualified by rst so br_taken or ID fields cannot leak
  // through while the unit is held in reset.
  assign hz.mul_busy = rst & mul_busy;
  assign hz.ex_hold  = rst & mul_busy;
  assign hz.pc_hold  = rst & (mul_busy | (luse & ~br_eff));
  assign hz.idex_bub = rst & luse & ~mul_busy & ~br_eff;
  assign hz.flush    = {FLUSH_DEPTH{rst & br_eff}};
  assign hz.fwd_a    = rst ? fwd_a_sel : 2'b00;
  assign hz.fwd_b    = rst ? fwd_b_sel : 2'b00;

endmodule

// File: tb/tb_hazard_unit_p.sv
// Purpose: drives directed and random instruction streams into hazard_unit_p and compares every cycle to a model.
// Latency: outputs are sampled 1 time unit after the negedge that applies the ID fields.
// Backpressure: the bench re-presents the same ID instruction whenever the model says IF/ID is held.
module tb_hazard_unit_p;
  localparam int MUL_LAT = 4;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       regw;
    logic       load;
    logic       mul;
  } ins_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_unit_p_if #(.REG_AW(5), .FLUSH_DEPTH(2)) hz();

  hazard_unit_p #(.REG_AW(5), .MUL_LAT(MUL_LAT), .FLUSH_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: what instruction is in each stage and how long the EX one has been there
  ins_t m_ex, m_mem, m_wb;
  int   m_age;
  logic last_ph;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] rd, input logic regw,
                              input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt,
                              input logic load, input logic mul);
    ins_t r;
    r.vld = 1'b1; r.rd = rd; r.regw = regw; r.rs = rs; r.use_rs = urs;
    r.rt = rt; r.use_rt = urt; r.load = load; r.mul = mul;
    return r;
  endfunction

  // an older instruction still in MEM or WB that writes src is a source
  function automatic int fsrc(input logic [4:0] src, input logic use_src);
    if (!(m_ex.vld && use_src)) return 0;
    if (m_mem.vld && m_mem.regw && m_mem.rd != 0 && m_mem.rd == src) return 2;
    if (m_wb.vld && m_wb.regw && m_wb.rd != 0 && m_wb.rd == src) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_age = 0; last_ph = 1'b0;
  endtask

  task automatic drive(input ins_t in, input logic br);
    hz.id_valid  = in.vld;
    hz.id_rs     = in.rs;
    hz.id_rt     = in.rt;
    hz.id_use_rs = in.use_rs;
    hz.id_use_rt = in.use_rt;
    hz.id_rd     = in.rd;
    hz.id_regw   = in.regw;
    hz.id_load   = in.load;
    hz.id_mul    = in.mul;
    hz.br_taken  = br;
  endtask

  // one pipeline cycle: apply ID, compare all outputs with the model, advance the model
  task automatic step(input ins_t in, input logic br);
    logic busy, luse, bre, ph;
    @(negedge clk);
    drive(in, br);
    #1;
    busy = m_ex.vld && m_ex.mul && (m_age < MUL_LAT - 1);
    luse = in.vld && m_ex.vld && m_ex.load && m_ex.regw && m_ex.rd != 0 &&
           ((in.use_rs && in.rs == m_ex.rd) || (in.use_rt && in.rt == m_ex.rd));
    bre  = br && !busy;
    ph   = busy || (luse && !bre);
    chk("pc_hold",  hz.pc_hold,  ph);
    chk("idex_bub", hz.idex_bub, luse && !busy && !bre);
    chk("ex_hold",  hz.ex_hold,  busy);
    chk("mul_busy", hz.mul_busy, busy);
    chk("flush",    hz.flush,    bre ? 3 : 0);
    chk("fwd_a",    hz.fwd_a,    fsrc(m_ex.rs, m_ex.use_rs));
    chk("fwd_b",    hz.fwd_b,    fsrc(m_ex.rt, m_ex.use_rt));
    last_ph = ph;
    m_wb = m_mem;
    if (busy) begin
      m_mem = '0;
      m_age++;
    end else begin
      m_mem = m_ex;
      m_ex  = (in.vld && !luse && !bre) ? in : '0;
      m_age = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step('0, 1'b0);
  endtask

  function automatic ins_t rnd_ins();
    ins_t r;
    int   kind;
    kind     = $urandom_range(0, 5);
    r.vld    = ($urandom_range(0, 99) < 85);
    r.rd     = 5'($urandom_range(0, 3));
    r.rs     = 5'($urandom_range(0, 3));
    r.rt     = 5'($urandom_range(0, 3));
    r.use_rs = 1'($urandom_range(0, 1));
    r.use_rt = 1'($urandom_range(0, 1));
    r.regw   = ($urandom_range(0, 7) != 0);
    r.load   = (kind == 0);
    r.mul    = (kind == 1);
    return r;
  endfunction

  initial begin
    ins_t lw2, add_dep, add1, sub5, or6, mul7, add8, dep9, or10, add7, mul11, cur;
    int   nbusy, nhold;
    total = 0; bad = 0;
    rst = 1'b0;
    drive('0, 1'b1);
    model_reset();
    #1;
    chk("rst_pc_hold",  hz.pc_hold,  0);
    chk("rst_flush",    hz.flush,    0);
    chk("rst_mul_busy", hz.mul_busy, 0);
    chk("rst_fwd_a",    hz.fwd_a,    0);
    @(negedge clk);
    drive('0, 1'b0);
    rst = 1'b1;
    drain();

    // lw r2 ; add r3,r2,r4 : one stall cycle, then WB forwarding
    lw2     = mk(5'd2, 1, 5'd0, 0, 5'd0, 0, 1, 0);
    add_dep = mk(5'd3, 1, 5'd2, 1, 5'd4, 1, 0, 0);
    step(lw2, 0);
    step(add_dep, 0);
    chk("lu_pc_hold", hz.pc_hold, 1);
    chk("lu_bub",     hz.idex_bub, 1);
    step(add_dep, 0);
    chk("lu_pc_hold_2", hz.pc_hold, 0);
    step('0, 0);
    chk("lu_fwd_a", hz.fwd_a, 1);
    chk("lu_fwd_b", hz.fwd_b, 0);
    drain();

    // add r1 ; sub r5,r1,r1 : EX/MEM forwarding on both operands
    add1 = mk(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
    sub5 = mk(5'd5, 1, 5'd1, 1, 5'd1, 1, 0, 0);
    step(add1, 0);
    step(sub5, 0);
    chk("alu_no_stall", hz.pc_hold, 0);
    step('0, 0);
    chk("alu_fwd_a", hz.fwd_a, 2);
    chk("alu_fwd_b", hz.fwd_b, 2);
    drain();

    // add r1 ; nop ; or r6,r1 : MEM/WB forwarding
    or6 = mk(5'd6, 1, 5'd1, 1, 5'd0, 0, 0, 0);
    step(add1, 0);
    step('0, 0);
    step(or6, 0);
    step('0, 0);
    chk("gap_fwd_a", hz.fwd_a, 1);
    drain();

    // r0 as destination is never a hazard source
    step(mk(5'd0, 1, 5'd0, 0, 5'd0, 0, 1, 0), 0);
    step(mk(5'd3, 1, 5'd0, 1, 5'd0, 1, 0, 0), 0);
    chk("r0_no_stall", hz.pc_hold, 0);
    drain();
    step(mk(5'd0, 1, 5'd2, 1, 5'd3, 1, 0, 0), 0);
    step(mk(5'd5, 1, 5'd0, 1, 5'd0, 1, 0, 0), 0);
    step('0, 0);
    chk("r0_fwd_a", hz.fwd_a, 0);
    chk("r0_fwd_b", hz.fwd_b, 0);
    drain();

    // mul r7 ; add r8,r7 : three busy cycles, then EX/MEM forwarding
    mul7 = mk(5'd7, 1, 5'd1, 1, 5'd2, 1, 0, 1);
    add8 = mk(5'd8, 1, 5'd7, 1, 5'd0, 0, 0, 0);
    step(mul7, 0);
    nbusy = 0; nhold = 0;
    for (int i = 0; i < 4; i++) begin
      step(add8, 0);
      if (hz.mul_busy) nbusy++;
      if (hz.ex_hold) nhold++;
    end
    chk("mul_busy_cycles", nbusy, 3);
    chk("mul_hold_cycles", nhold, 3);
    step('0, 0);
    chk("mul_fwd_a", hz.fwd_a, 2);
    drain();

    // taken branch over a load-use: flush both, no stall, dependent killed
    dep9 = mk(5'd9,  1, 5'd2, 1, 5'd2, 1, 0, 0);
    or10 = mk(5'd10, 1, 5'd9, 1, 5'd0, 0, 0, 0);
    step(lw2, 0);
    step(dep9, 1);
    chk("br_flush",    hz.flush, 3);
    chk("br_pc_hold",  hz.pc_hold, 0);
    chk("br_idex_bub", hz.idex_bub, 0);
    step(or10, 0);
    step('0, 0);
    chk("br_killed_fwd", hz.fwd_a, 0);
    drain();

    // asynchronous reset while the MUL counter sits at 2
    add7  = mk(5'd7,  1, 5'd1, 1, 5'd1, 1, 0, 0);
    mul11 = mk(5'd11, 1, 5'd7, 1, 5'd7, 1, 0, 1);
    step(add7, 0);
    step(mul11, 0);
    step('0, 0);
    step('0, 0);
    chk("pre_rst_busy",  hz.mul_busy, 1);
    chk("pre_rst_fwd_a", hz.fwd_a, 1);
    rst = 1'b0;
    hz.br_taken = 1'b1;
    #1;
    chk("arst_mul_busy", hz.mul_busy, 0);
    chk("arst_fwd_a",    hz.fwd_a, 0);
    chk("arst_fwd_b",    hz.fwd_b, 0);
    chk("arst_pc_hold",  hz.pc_hold, 0);
    chk("arst_flush",    hz.flush, 0);
    model_reset();
    @(negedge clk);
    drive('0, 1'b0);
    rst = 1'b1;
    drain();

    // random streams; the ID instruction is re-presented while IF/ID is held
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!last_ph) cur = rnd_ins();
      step(cur, ($urandom_range(0, 7) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
